pkt_noc_packetizer: RTL and testbench

PKT_NOC_PACKETIZER -- requirements
Module: pkt_noc_packetizer

---
 rtl/pkt_noc_packetizer.sv | 191 +++++++++++++++++++
 tb/tb_pkt_noc_packetizer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_noc_packetizer.sv
// pkt_noc_packetizer
//   Maps each accepted 512-bit streaming beat to one 600-bit NoC flit made of
//   four 150-bit slots: {valid, sop, eop, sideband[18:0], data[127:0]}.
//   The head slot carries dest/vc/type routing, and the eop slot carries the
//   count of unused bytes. A 2-entry output FIFO decouples the NoC
//   backpressure from the input side.
// Ports
//   clk, reset (async, active low)
//   i_data_in/i_valid_in/i_sop_in/i_eop_in/i_empty_in/i_ddr_in  : beat input
//   i_ready_out                                                : beat accept
//   o_data_out/o_valid_out/o_ready_in                          : flit output
//   o_pkt_cnt/o_err_cnt                                        : saturating stats

// One 150-bit slot of the flit. The slot is valid when it lies in the top
// n_valid slots. The lowest valid slot takes eop on an eop beat.
module pkt_noc_packetizer_slot #(
  parameter int SLOT_IDX = 0,
  parameter int SLOT_W   = 150,
  parameter int LANE_W   = 128
) (
  input  logic [2:0]               n_valid,
  input  logic                     eop_beat,
  input  logic                     head,
  input  logic [SLOT_W-LANE_W-4:0] hdr_sb,
  input  logic [3:0]               unused,
  input  logic [LANE_W-1:0]        data,
  output logic [SLOT_W-1:0]        slot
);
  localparam int SB_W = SLOT_W - LANE_W - 3;
  localparam logic [3:0] IDX = 4'(SLOT_IDX);

  logic            is_valid, is_low, is_head, is_eop;
  logic [SB_W-1:0] sb;

  always_comb begin
    // Slot k is valid when k >= 4 - n, and it is the lowest valid slot when k == 4 - n.
    is_valid = (IDX + {1'b0, n_valid}) >= 4'd4;
    is_low   = (IDX + {1'b0, n_valid}) == 4'd4;
    is_head  = head && (SLOT_IDX == 3);
    is_eop   = eop_beat && is_low;
    sb       = '0;
    if (is_head) sb = hdr_sb;
    // The head fields sit in the upper sideband bits, so they never overlap the unused count.
    if (is_eop)  sb[3:0] = unused;
    slot = is_valid ? {1'b1, is_head, is_eop, sb, data} : '0;
  end
endmodule

module pkt_noc_packetizer #(
  parameter int DATA_WIDTH = 512,
  parameter int NOC_WIDTH  = 600,
  parameter int NUM_VC     = 2,
  parameter int NOC_RADIX  = 16,
  parameter int IPV4_DEST  = 4,
  parameter int DDR_DEST   = 12,
  parameter int VC_ID      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_valid_in,
  input  logic                  i_sop_in,
  input  logic                  i_eop_in,
  input  logic [5:0]            i_empty_in,
  input  logic                  i_ddr_in,
  output logic                  i_ready_out,
  output logic [NOC_WIDTH-1:0]  o_data_out,
  output logic                  o_valid_out,
  input  logic                  o_ready_in,
  output logic [15:0]           o_pkt_cnt,
  output logic [15:0]           o_err_cnt
);
  localparam int SLOT_W = NOC_WIDTH / 4;
  localparam int LANE_W = DATA_WIDTH / 4;
  localparam int SB_W   = SLOT_W - LANE_W - 3;
  localparam int DEST_W = $clog2(NOC_RADIX);
  localparam int VC_W   = $clog2(NUM_VC);
  localparam int PAD_W  = SB_W - DEST_W - VC_W - 2;
  localparam logic [DEST_W-1:0] DDR_D  = DEST_W'(DDR_DEST);
  localparam logic [DEST_W-1:0] IPV4_D = DEST_W'(IPV4_DEST);
  localparam logic [VC_W-1:0]   VC_B   = VC_W'(VC_ID);

  typedef enum logic {IDLE, BODY} state_e;

  state_e                     state_q, state_d;
  logic [1:0][NOC_WIDTH-1:0]  mem_q, mem_d;
  logic                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic                       rdy_en_q;
  logic [15:0]                pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

  logic                       accept, emit, err_inc, pop, out_eop;
  logic [5:0]                 eff_empty;
  logic [2:0]                 n_valid;
  logic [3:0]                 unused;
  logic [SB_W-1:0]            hdr_sb;
  logic [NOC_WIDTH-1:0]       flit;

  // The ready signal stays low in reset and rises on the first edge after reset is released.
  assign i_ready_out = rdy_en_q && (cnt_q != 2'd2);
  assign accept      = i_valid_in && i_ready_out;
  assign o_valid_out = (cnt_q != 2'd0);
  assign o_data_out  = o_valid_out ? mem_q[rd_ptr_q] : '0;
  assign pop         = o_valid_out && o_ready_in;
  assign o_pkt_cnt   = pkt_cnt_q;
  assign o_err_cnt   = err_cnt_q;

  // ceil((64-e)/16) == 4 - e[5:4], and the unused bytes in the last slot equal e mod 16.
  assign eff_empty = i_eop_in ? i_empty_in : 6'd0;
  assign n_valid   = 3'd4 - {1'b0, eff_empty[5:4]};
  assign unused    = eff_empty[3:0];
  assign hdr_sb    = {i_ddr_in ? DDR_D : IPV4_D, VC_B,
                      i_ddr_in ? 2'b01 : 2'b00, {PAD_W{1'b0}}};

  for (genvar k = 0; k < 4; k++) begin : g_slot
    pkt_noc_packetizer_slot #(
      .SLOT_IDX (k),
      .SLOT_W   (SLOT_W),
      .LANE_W   (LANE_W)
    ) u_slot (
      .n_valid  (n_valid),
      .eop_beat (i_eop_in),
      .head     (i_sop_in),
      .hdr_sb   (hdr_sb),
      .unused   (unused),
      .data     (i_data_in[k*LANE_W +: LANE_W]),
      .slot     (flit[k*SLOT_W +: SLOT_W])
    );
  end

  // A sop beat always opens a new packet. In BODY it also abandons the old one.
  // A non-sop beat outside a packet is accepted and then dropped.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    err_inc = 1'b0;
    if (accept) begin
      if (i_sop_in) begin
        emit    = 1'b1;
        err_inc = (state_q == BODY);
        state_d = i_eop_in ? IDLE : BODY;
      end else if (state_q == BODY) begin
        emit = 1'b1;
        if (i_eop_in) state_d = IDLE;
      end else begin
        err_inc = 1'b1;
      end
    end
  end

  always_comb begin
    out_eop = 1'b0;
    for (int k = 0; k < 4; k++) out_eop = out_eop | o_data_out[k*SLOT_W + SLOT_W - 3];
  end

  // The FIFO has two entries. A write never targets the entry being presented,
  // so o_data_out holds steady while the output is stalled.
  always_comb begin
    mem_d = mem_q;
    if (emit) mem_d[wr_ptr_q] = flit;
    wr_ptr_d  = wr_ptr_q ^ emit;
    rd_ptr_d  = rd_ptr_q ^ pop;
    cnt_d     = cnt_q + {1'b0, emit} - {1'b0, pop};
    pkt_cnt_d = pkt_cnt_q;
    if (pop && out_eop && (pkt_cnt_q != 16'hFFFF)) pkt_cnt_d = pkt_cnt_q + 16'd1;
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mem_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      rdy_en_q  <= 1'b0;
      pkt_cnt_q <= 16'd0;
      err_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rdy_en_q  <= 1'b1;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_pkt_noc_packetizer.sv
// Self-checking bench for pkt_noc_packetizer. A queue-based reference model
// builds the expected flits from byte counts. It tracks the output FIFO
// occupancy and the packet counters.
module tb_pkt_noc_packetizer;
  logic         clk, reset;
  logic [511:0] i_data_in;
  logic         i_valid_in, i_sop_in, i_eop_in, i_ddr_in;
  logic [5:0]   i_empty_in;
  logic         i_ready_out;
  logic [599:0] o_data_out;
  logic         o_valid_out, o_ready_in;
  logic [15:0]  o_pkt_cnt, o_err_cnt;

  pkt_noc_packetizer dut (
    .clk         (clk),
    .reset       (reset),
    .i_data_in   (i_data_in),
    .i_valid_in  (i_valid_in),
    .i_sop_in    (i_sop_in),
    .i_eop_in    (i_eop_in),
    .i_empty_in  (i_empty_in),
    .i_ddr_in    (i_ddr_in),
    .i_ready_out (i_ready_out),
    .o_data_out  (o_data_out),
    .o_valid_out (o_valid_out),
    .o_ready_in  (o_ready_in),
    .o_pkt_cnt   (o_pkt_cnt),
    .o_err_cnt   (o_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [599:0] exp_q[$];
  bit           eop_q[$];
  bit           m_busy, m_rdy_en;
  logic [15:0]  m_pkt, m_err;
  logic [511:0] d0, d1, d2;
  logic [599:0] held;

  task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // The flit is built from the slot position counted down from the top slot:
  // position j covers bytes 16j..16j+15 and lands in slot 3-j.
  function automatic logic [599:0] mk_flit(input bit sop, input bit eop, input bit ddr,
                                           input logic [5:0] emp, input logic [511:0] d);
    logic [599:0] f;
    int nbytes, n, base;
    f = '0;
    nbytes = eop ? 64 - int'(emp) : 64;
    n = (nbytes + 15) / 16;
    for (int j = 0; j < n; j++) begin
      base = 150 * (3 - j);
      f[base + 149] = 1'b1;
      f[base +: 128] = d[128*(3-j) +: 128];
      if (sop && j == 0) begin
        f[base + 148] = 1'b1;
        f[base + 143 +: 4] = ddr ? 4'd12 : 4'd4;
        f[base + 142] = 1'b0;
        f[base + 140 +: 2] = ddr ? 2'b01 : 2'b00;
      end
      if (eop && j == n - 1) begin
        f[base + 147] = 1'b1;
        f[base + 128 +: 4] = 4'(n * 16 - nbytes);
      end
    end
    return f;
  endfunction

  // One clock: check the outputs, let the edge pass, then advance the model.
  task automatic cycle();
    bit m_ready, acc, pop, sop, eop, ddr;
    logic [5:0]   emp;
    logic [511:0] d;
    m_ready = m_rdy_en && (exp_q.size() < 2);
    chk("ready", 600'(i_ready_out), 600'(m_ready));
    chk("valid", 600'(o_valid_out), 600'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("data", o_data_out, exp_q[0]);
    else                   chk("data_idle", o_data_out, '0);
    chk("pkt_cnt", 600'(o_pkt_cnt), 600'(m_pkt));
    chk("err_cnt", 600'(o_err_cnt), 600'(m_err));
    acc = i_valid_in && m_ready;
    pop = (exp_q.size() != 0) && o_ready_in;
    sop = i_sop_in; eop = i_eop_in; ddr = i_ddr_in; emp = i_empty_in; d = i_data_in;
    @(posedge clk);
    if (pop) begin
      if (eop_q[0]) m_pkt = sat_inc(m_pkt);
      void'(exp_q.pop_front());
      void'(eop_q.pop_front());
    end
    if (acc) begin
      if (sop) begin
        if (m_busy) m_err = sat_inc(m_err);
        exp_q.push_back(mk_flit(1'b1, eop, ddr, emp, d));
        eop_q.push_back(eop);
        m_busy = !eop;
      end else if (m_busy) begin
        exp_q.push_back(mk_flit(1'b0, eop, ddr, emp, d));
        eop_q.push_back(eop);
        m_busy = !eop;
      end else begin
        m_err = sat_inc(m_err);
      end
    end
    m_rdy_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic beat(input bit sop, input bit eop, input bit ddr,
                      input logic [5:0] emp, input logic [511:0] d);
    bit ok, will;
    ok = 1'b0;
    i_valid_in = 1'b1; i_sop_in = sop; i_eop_in = eop;
    i_ddr_in = ddr; i_empty_in = emp; i_data_in = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      will = m_rdy_en && (exp_q.size() < 2);
      cycle();
      ok = will;
    end
    chk("beat_accept", 600'(ok), 600'(1'b1));
    i_valid_in = 1'b0;
  endtask

  task automatic drain();
    i_valid_in = 1'b0;
    o_ready_in = 1'b1;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) cycle();
    chk("drain_empty", 600'(exp_q.size()), '0);
  endtask

  task automatic do_reset();
    i_valid_in = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_valid", 600'(o_valid_out), '0);
    chk("rst_data",  o_data_out, '0);
    chk("rst_ready", 600'(i_ready_out), '0);
    chk("rst_pkt",   600'(o_pkt_cnt), '0);
    chk("rst_err",   600'(o_err_cnt), '0);
    exp_q.delete(); eop_q.delete();
    m_busy = 1'b0; m_rdy_en = 1'b0; m_pkt = '0; m_err = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; i_valid_in = 1'b0; i_sop_in = 1'b0; i_eop_in = 1'b0;
    i_ddr_in = 1'b0; i_empty_in = '0; i_data_in = '0; o_ready_in = 1'b1;
    m_busy = 1'b0; m_rdy_en = 1'b0; m_pkt = '0; m_err = '0;
    @(negedge clk);
    do_reset();
    cycle();
    chk("ready_rise", 600'(i_ready_out), 600'(1'b1));

    // A single-beat IPv4 packet fills all four slots.
    d0 = rnd512();
    beat(1'b1, 1'b1, 1'b0, 6'd0, d0);
    chk("t1_b599",  600'(o_data_out[599]), 600'(1'b1));
    chk("t1_b598",  600'(o_data_out[598]), 600'(1'b1));
    chk("t1_s3eop", 600'(o_data_out[597]), '0);
    chk("t1_s0eop", 600'(o_data_out[147]), 600'(1'b1));
    chk("t1_s0val", 600'(o_data_out[149]), 600'(1'b1));
    chk("t1_dest",  600'(o_data_out[596:593]), 600'(4'd4));
    chk("t1_type",  600'(o_data_out[591:590]), '0);
    chk("t1_s0dat", 600'(o_data_out[127:0]), 600'(d0[127:0]));
    chk("t1_s3dat", 600'(o_data_out[577:450]), 600'(d0[511:384]));
    cycle();
    chk("t1_pkt", 600'(o_pkt_cnt), 600'(16'd1));

    // A three-beat DDR packet whose last beat has empty = 40.
    d0 = rnd512(); d1 = rnd512(); d2 = rnd512();
    beat(1'b1, 1'b0, 1'b1, 6'd0, d0);
    chk("t2_dest", 600'(o_data_out[596:593]), 600'(4'd12));
    chk("t2_type", 600'(o_data_out[591:590]), 600'(2'b01));
    chk("t2_f1s0", 600'(o_data_out[149]), 600'(1'b1));
    beat(1'b0, 1'b0, 1'b1, 6'd9, d1);
    chk("t2_f2s0", 600'(o_data_out[149]), 600'(1'b1));
    chk("t2_f2sop", 600'(o_data_out[598]), '0);
    beat(1'b0, 1'b1, 1'b0, 6'd40, d2);
    chk("t2_s3val", 600'(o_data_out[599]), 600'(1'b1));
    chk("t2_s2val", 600'(o_data_out[449]), 600'(1'b1));
    chk("t2_s2eop", 600'(o_data_out[447]), 600'(1'b1));
    chk("t2_s2sb",  600'(o_data_out[446:428]), 600'(19'd8));
    chk("t2_low",   600'(o_data_out[299:0]), '0);
    drain();

    // Protocol errors: an orphan body beat, then a sop arriving mid-packet.
    beat(1'b0, 1'b1, 1'b0, 6'd3, rnd512());
    chk("t3_nodrop", 600'(o_valid_out), '0);
    chk("t3_err1",   600'(o_err_cnt), 600'(16'd1));
    beat(1'b1, 1'b0, 1'b0, 6'd0, rnd512());
    beat(1'b1, 1'b0, 1'b1, 6'd0, rnd512());
    chk("t3_head",  600'(o_data_out[598]), 600'(1'b1));
    chk("t3_err2",  600'(o_err_cnt), 600'(16'd2));
    beat(1'b0, 1'b1, 1'b1, 6'd17, rnd512());
    drain();

    // Output stall: two beats fit in the FIFO, and the third waits.
    o_ready_in = 1'b0;
    beat(1'b1, 1'b0, 1'b0, 6'd0, rnd512());
    held = o_data_out;
    beat(1'b0, 1'b0, 1'b0, 6'd0, rnd512());
    d2 = rnd512();
    i_valid_in = 1'b1; i_sop_in = 1'b0; i_eop_in = 1'b1; i_empty_in = 6'd63; i_data_in = d2;
    for (int t = 0; t < 3; t++) begin
      cycle();
      chk("t4_hold",  o_data_out, held);
      chk("t4_nrdy",  600'(i_ready_out), '0);
    end
    o_ready_in = 1'b1;
    beat(1'b0, 1'b1, 1'b0, 6'd63, d2);
    drain();

    // Reset with two flits buffered, then a clean packet.
    o_ready_in = 1'b0;
    beat(1'b1, 1'b0, 1'b1, 6'd0, rnd512());
    beat(1'b0, 1'b0, 1'b1, 6'd0, rnd512());
    do_reset();
    o_ready_in = 1'b1;
    cycle();
    d0 = rnd512();
    beat(1'b1, 1'b1, 1'b1, 6'd20, d0);
    chk("t5_flit", o_data_out, mk_flit(1'b1, 1'b1, 1'b1, 6'd20, d0));
    drain();

    // Random traffic with random backpressure and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
      end else begin
        o_ready_in = ($urandom_range(3) != 0);
        i_valid_in = ($urandom_range(3) != 0);
        i_sop_in   = ($urandom_range(3) == 0);
        i_eop_in   = ($urandom_range(2) == 0);
        i_ddr_in   = $urandom_range(1);
        i_empty_in = 6'($urandom_range(63));
        i_data_in  = rnd512();
        cycle();
      end
    end
    drain();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
